pdetect_mc: RTL

- Multi-channel, time-multiplexed successor to the single-channel phase-wrap detector.
- Tracks wraps of each channel's w-bit angle through ±pi, with a saturating per-channel wrap count of configurable depth.
- Emits two outputs per sample: a saturated w-bit angle (PFD-style pinning) and an extended-width unwrapped angle.
- Sits after CORDIC/phase extraction, feeding phase-lock loop filters for several cavities or channels sharing one datapath.

---
 rtl/pdetect_mc.sv | 96 +++++++++
 1 files changed

// File: rtl/pdetect_mc.sv
// rtl/pdetect_mc.sv - time-multiplexed multi-channel phase-wrap detector with saturating wrap counts
module pdetect_mc #(
    parameter int w   = 18,
    parameter int cw  = 2,
    parameter int nch = 2,
    parameter int chw = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       strobe_in,
    input  logic                       first_in,
    input  logic signed [w-1:0]        ang_in,
    input  logic                       clear_in,
    output logic signed [w-1:0]        ang_out,
    output logic signed [w+cw-1:0]     ext_out,
    output logic                       sat_out,
    output logic [chw-1:0]             ch_out,
    output logic                       strobe_out
);

    localparam logic signed [w-1:0]  qpos = w'(1) << (w - 2);
    localparam logic signed [w-1:0]  qneg = -qpos;
    localparam logic signed [cw-1:0] smax = cw'((1 << (cw - 1)) - 1);
    localparam logic signed [cw-1:0] smin = -smax;

    logic signed [w-1:0]  prev [nch];
    logic signed [cw-1:0] cnt  [nch];
    logic [chw-1:0]       ptr;

    logic [chw-1:0]       idx;
    logic [chw-1:0]       idx_next;
    logic signed [w-1:0]  p;
    logic signed [cw-1:0] s_cur;
    logic signed [cw-1:0] s_new;
    logic                 up_wrap;
    logic                 down_wrap;
    logic signed [w-1:0]  ang_sat;
    logic signed [w+cw-1:0] ext_val;

    always_comb begin
        idx       = first_in ? '0 : ptr;
        idx_next  = (idx == chw'(nch - 1)) ? '0 : idx + 1'b1;
        p         = prev[idx];
        // a coincident clear means this sample sees a zero count before wrap detection
        s_cur     = clear_in ? '0 : cnt[idx];
        up_wrap   = (p >= qpos) && (ang_in < qneg);
        down_wrap = (p < qneg) && (ang_in >= qpos);
        s_new     = s_cur;
        if (up_wrap && (s_cur != smax)) begin
            s_new = s_cur + 1'b1;
        end else if (down_wrap && (s_cur != smin)) begin
            s_new = s_cur - 1'b1;
        end
        if (s_new == '0) begin
            ang_sat = ang_in;
        end else if (s_new[cw-1]) begin
            ang_sat = {1'b1, {(w-1){1'b0}}};
        end else begin
            ang_sat = {1'b0, {(w-1){1'b1}}};
        end
        ext_val = {{cw{ang_in[w-1]}}, ang_in} + {s_new, {w{1'b0}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < nch; i++) begin
                prev[i] <= '0;
                cnt[i]  <= '0;
            end
            ptr        <= '0;
            ang_out    <= '0;
            ext_out    <= '0;
            sat_out    <= 1'b0;
            ch_out     <= '0;
            strobe_out <= 1'b0;
        end else begin
            if (clear_in) begin
                for (int i = 0; i < nch; i++) begin
                    cnt[i] <= '0;
                end
            end
            strobe_out <= strobe_in;
            // the per-sample count write below takes priority over the clear above
            if (strobe_in) begin
                prev[idx] <= ang_in;
                cnt[idx]  <= s_new;
                ptr       <= idx_next;
                ang_out   <= ang_sat;
                ext_out   <= ext_val;
                sat_out   <= (s_new == smax) || (s_new == smin);
                ch_out    <= idx;
            end
        end
    end

endmodule
